// File: rtl/rv_pkg.sv
// Shared definitions for the data bus: bus widths, slave address map and FSM states.
package rv_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned BE_W    = XLEN / 8;
    localparam int unsigned MAX_SLV = 8;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned TMR_W   = 16;

    // Slaves 2 and 3 overlap at 0xA000_0000..0xA00F_FFFF; the lower index owns that window.
    localparam logic [XLEN-1:0] SLV_BASE [MAX_SLV] = '{
        32'h0000_0000, 32'h8000_0000, 32'hA000_0000, 32'hA000_0000,
        32'hB000_0000, 32'hC000_0000, 32'hD000_0000, 32'hE000_0000
    };

    localparam logic [XLEN-1:0] SLV_MASK [MAX_SLV] = '{
        32'hF000_0000, 32'hFFF0_0000, 32'hFFF0_0000, 32'hFF00_0000,
        32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } bus_state_e;

endpackage

// File: rtl/rv_addr_decode.sv
// Combinational address decoder: flags a hit and returns the lowest matching slave index.
//   addr : host address
//   hit  : at least one slave window matches
//   idx  : index of the lowest-numbered matching slave (0 when no hit)
module rv_addr_decode
    import rv_pkg::*;
#(
    parameter int unsigned NSLV = 4
) (
    input  logic [XLEN-1:0]  addr,
    output logic             hit,
    output logic [SEL_W-1:0] idx
);

    // Scan from the top down so the last assignment, the lowest index, wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = int'(NSLV) - 1; k >= 0; k--) begin
            if ((addr & SLV_MASK[k]) == SLV_BASE[k]) begin
                hit = 1'b1;
                idx = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/rv_data_bus.sv
// Single-outstanding host-to-slave data bus with address decode, response timeout and
// error responses for unmapped addresses.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   data_req/we/be/addr/wdata_i : host request
//   data_gnt_o              : request accepted this cycle (FSM idle)
//   data_rvalid/rdata/err_o : host response, one-cycle pulse
//   data_req_o (one-hot), data_we/be/addr/wdata_o : forwarded slave request
//   data_rvalid_i, data_rdata_i : per-slave response
//   busy_o                  : transaction in flight
module rv_data_bus
    import rv_pkg::*;
#(
    parameter int unsigned NSLV    = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 data_req_i,
    input  logic                 data_we_i,
    input  logic [BE_W-1:0]      data_be_i,
    input  logic [XLEN-1:0]      data_addr_i,
    input  logic [XLEN-1:0]      data_wdata_i,
    output logic                 data_gnt_o,
    output logic                 data_rvalid_o,
    output logic [XLEN-1:0]      data_rdata_o,
    output logic                 data_err_o,
    output logic [NSLV-1:0]      data_req_o,
    output logic                 data_we_o,
    output logic [BE_W-1:0]      data_be_o,
    output logic [XLEN-1:0]      data_addr_o,
    output logic [XLEN-1:0]      data_wdata_o,
    input  logic [NSLV-1:0]      data_rvalid_i,
    input  logic [NSLV*XLEN-1:0] data_rdata_i,
    output logic                 busy_o
);

    bus_state_e       state;
    logic [NSLV-1:0]  sel_oh;
    logic [TMR_W-1:0] timer;

    logic             dec_hit;
    logic [SEL_W-1:0] dec_idx;
    logic             rsp_valid;
    logic [XLEN-1:0]  rsp_data;

    rv_addr_decode #(.NSLV(NSLV)) u_decode (
        .addr (data_addr_i),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    // Only the selected slave's response is visible; others are masked off.
    always_comb begin
        rsp_valid = |(data_rvalid_i & sel_oh);
        rsp_data  = '0;
        for (int k = 0; k < int'(NSLV); k++) begin
            if (sel_oh[k]) begin
                rsp_data = data_rdata_i[k*XLEN +: XLEN];
            end
        end
    end

    assign data_gnt_o = (state == IDLE);
    assign busy_o     = (state != IDLE);

    // Bus FSM with registered slave request and host response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            sel_oh        <= '0;
            timer         <= '0;
            data_req_o    <= '0;
            data_we_o     <= 1'b0;
            data_be_o     <= '0;
            data_addr_o   <= '0;
            data_wdata_o  <= '0;
            data_rvalid_o <= 1'b0;
            data_err_o    <= 1'b0;
            data_rdata_o  <= '0;
        end else begin
            data_req_o    <= '0;
            data_rvalid_o <= 1'b0;
            data_err_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_req_i) begin
                        if (dec_hit) begin
                            state        <= WAIT;
                            sel_oh       <= NSLV'(1'b1) << dec_idx;
                            data_req_o   <= NSLV'(1'b1) << dec_idx;
                            data_we_o    <= data_we_i;
                            data_be_o    <= data_be_i;
                            data_addr_o  <= data_addr_i - SLV_BASE[dec_idx];
                            data_wdata_o <= data_wdata_i;
                            timer        <= '0;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                WAIT: begin
                    // A response in the final timer cycle still beats the timeout.
                    if (rsp_valid) begin
                        data_rvalid_o <= 1'b1;
                        data_rdata_o  <= rsp_data;
                        state         <= IDLE;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        data_rvalid_o <= 1'b1;
                        data_err_o    <= 1'b1;
                        data_rdata_o  <= '0;
                        state         <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ERR: begin
                    data_rvalid_o <= 1'b1;
                    data_err_o    <= 1'b1;
                    data_rdata_o  <= '0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rv_data_bus.md
RV_DATA_BUS -- requirements
Module: rv_data_bus

Interface
REQ-001 The block SHALL have parameter NSLV, default 4, giving the number of slave ports (1..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum number of cycles to wait for a slave response (1..65535).
REQ-003 Port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_i, input, 1 bit: reset, which SHALL be synchronous and active-high.
REQ-005 Host side ports:
- data_req_i, input, 1 bit: request strobe.
- data_we_i, input, 1 bit: write enable.
- data_be_i, input, XLEN/8 bits: byte enables.
- data_addr_i, input, XLEN bits: address.
- data_wdata_i, input, XLEN bits: write data.
REQ-006 Host side response and status ports:
- data_gnt_o, output, 1 bit: the block accepts a request this cycle.
- data_rvalid_o, output, 1 bit: response valid.
- data_rdata_o, output, XLEN bits: read data.
- data_err_o, output, 1 bit: error qualifier on the response.
REQ-007 Slave side ports:
- data_req_o, output, NSLV bits: one-hot request.
- data_we_o, output, 1 bit; data_be_o, output, XLEN/8 bits: forwarded write enable and byte enables.
- data_addr_o, output, XLEN bits: slave-relative address.
- data_wdata_o, output, XLEN bits: forwarded write data.
- data_rvalid_i, input, NSLV bits: per-slave response valid.
- data_rdata_i, input, NSLV*XLEN bits: slave k read data in bits [k*XLEN +: XLEN].
REQ-008 Port busy_o, output, 1 bit: a transaction is in flight.

Function
REQ-009 The FSM SHALL have three states, IDLE, WAIT and ERR, and data_gnt_o SHALL equal (state==IDLE).
REQ-010 In IDLE with data_req_i=1, slave k SHALL hit when (data_addr_i & SLV_MASK[k])==SLV_BASE[k]; if several slaves hit, the lowest index SHALL win.
REQ-011 On a hit, the block SHALL register the request fields and assert data_req_o[k] for exactly one cycle (the cycle after acceptance).
- data_addr_o SHALL be data_addr_i - SLV_BASE[k], computed modulo 2^XLEN.
- The FSM SHALL then enter WAIT with sel=k and the timer at 0.
REQ-012 On a miss, the FSM SHALL enter ERR, issue no slave request, and in the next cycle drive data_rvalid_o=1, data_err_o=1, data_rdata_o=0, then return to IDLE.
REQ-013 In WAIT, data_rvalid_i[sel]=1 SHALL cause the following cycle to drive data_rvalid_o=1, data_err_o=0 and data_rdata_o equal to the registered slave data; the FSM then returns to IDLE.
REQ-014 In WAIT, data_rvalid_i of non-selected slaves SHALL be ignored.
REQ-015 Writes SHALL also wait for a slave data_rvalid_i; for writes, data_rdata_o SHALL be passed through unmodified.
REQ-016 In WAIT, the timer SHALL increment each cycle without a response. When it reaches TIMEOUT, the block SHALL respond as in REQ-012 (err=1, rdata=0).
- A response arriving in the same cycle that the timer reaches TIMEOUT SHALL win (err=0).
REQ-017 A data_req_i asserted outside IDLE SHALL be ignored, with no queueing.
REQ-018 data_rvalid_o SHALL be a single-cycle pulse. Whenever data_rvalid_o=0, data_err_o SHALL be 0.
REQ-019 busy_o SHALL equal (state!=IDLE).
REQ-020 The minimum hit latency SHALL be 3 cycles from acceptance to data_rvalid_o when the slave responds in the cycle after its request.

Reset
REQ-021 With rst_i=1 at a clock edge:
- state SHALL become IDLE and the timer 0.
- data_req_o, data_rvalid_o, data_err_o and busy_o SHALL become 0.
- data_rdata_o, data_addr_o, data_wdata_o, data_be_o and data_we_o SHALL become 0.
REQ-022 A reset asserted during WAIT SHALL abandon the transaction with no response pulse; a late slave data_rvalid_i after reset SHALL be ignored.

Structure
REQ-023 SLV_BASE, SLV_MASK (arrays of XLEN-bit constants, 8 entries) and the FSM state enum SHALL reside in rv_pkg.
REQ-024 The address match SHALL be a sub-module, rv_addr_decode, that returns the hit flag and winning index combinationally.

Verification
REQ-025 NSLV=4, SLV_BASE[1]=0x8000_0000, mask 0xFFF0_0000; read addr 0x8000_0010, slave 1 rvalid one cycle after req with 0x1234_5678 -> data_req_o=4'b0010 for 1 cycle, data_addr_o=0x10, rvalid_o with rdata 0x1234_5678 and err=0 at cycle 3.
REQ-026 Unmapped addr 0xF000_0000 -> no data_req_o; rvalid_o=1, err=1, rdata=0 two cycles after acceptance.
REQ-027 TIMEOUT=8, slave silent -> rvalid_o with err=1 exactly 8 cycles after the slave request, then gnt_o=1.
REQ-028 Slave 2 rvalid (0xAAAA_AAAA) while sel=1, then slave 1 rvalid (0x5555_5555) -> only one response, rdata 0x5555_5555.
REQ-029 rst_i asserted 2 cycles into WAIT, slave responds afterwards -> no rvalid_o; busy_o=0 and gnt_o=1 after reset.
REQ-030 data_req_i held during WAIT with a different addr -> ignored; exactly one slave request and one response observed.
